// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, ALU opcodes and the bypass-select encoding.
`default_nettype none

package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [4:0] ALU_LUI  = 5'b00000;
  localparam logic [4:0] ALU_ADDU = 5'b00001;
  localparam logic [4:0] ALU_ADD  = 5'b00010;
  localparam logic [4:0] ALU_SUBU = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_XOR  = 5'b00111;
  localparam logic [4:0] ALU_NOR  = 5'b01000;
  localparam logic [4:0] ALU_SLL  = 5'b01001;
  localparam logic [4:0] ALU_SRL  = 5'b01010;
  localparam logic [4:0] ALU_SRA  = 5'b01011;
  localparam logic [4:0] ALU_SLT  = 5'b10111;
  localparam logic [4:0] ALU_SLTU = 5'b11000;
  localparam logic [4:0] ALU_NOP  = ALU_ADDU;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/operand_forward.sv
// One-source bypass mux: EX/MEM result beats MEM/WB data beats the registered value;
// register 0 is never forwarded.
`default_nettype none

module operand_forward #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o
);
  import cpu_pkg::*;

  fwd_sel_e fwd_sel;

  always_comb begin
    fwd_sel = FWD_REG;
    if (mem_we_i && (mem_rd_i != '0) && (mem_rd_i == src_i)) begin
      fwd_sel = FWD_MEM;
    end else if (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == src_i)) begin
      fwd_sel = FWD_WB;
    end
  end

  always_comb begin
    data_o = reg_data_i;
    case (fwd_sel)
      FWD_MEM: data_o = mem_data_i;
      FWD_WB:  data_o = wb_data_i;
      default: data_o = reg_data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass and hazard stall generation.
// FORWARDING_EN selects the bypass network; without it every RAW hazard stalls instead.
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Hold,
  input  logic              Flush,
  input  logic              ID_Valid,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic [REG_AW-1:0] ID_Rd,
  input  logic              ID_UsesRs,
  input  logic              ID_UsesRt,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic              ID_ALUSrc,
  input  logic [OP_W-1:0]   ID_ALUOperation,
  input  logic [4:0]        ID_Shamt,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              MEM_RegWrite,
  input  logic [REG_AW-1:0] MEM_Rd,
  input  logic [DATA_W-1:0] MEM_Result,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_Rd,
  input  logic [DATA_W-1:0] WB_Data,
  output logic [DATA_W-1:0] Operand1,
  output logic [DATA_W-1:0] Operand2,
  output logic [OP_W-1:0]   ALUOperation,
  output logic [4:0]        Shamt,
  output logic [REG_AW-1:0] EX_Rd,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_Valid,
  output logic [DATA_W-1:0] EX_StoreData,
  output logic              StallIF_ID
);
  import cpu_pkg::*;

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic              alusrc_q, alusrc_d;
  logic [OP_W-1:0]   aluop_q, aluop_d;
  logic [4:0]        shamt_q, shamt_d;
  logic              regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  logic              load_use;

  function automatic logic src_hit(input logic uses, input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] dst);
    return uses && (src != '0) && (src == dst);
  endfunction

  assign load_use = valid_q && memread_q &&
                    (src_hit(ID_UsesRs, ID_Rs, rd_q) || src_hit(ID_UsesRt, ID_Rt, rd_q));

`ifdef FORWARDING_EN
  assign StallIF_ID = load_use;

  operand_forward #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src_i(rs_q), .reg_data_i(rs_data_q),
    .mem_we_i(MEM_RegWrite), .mem_rd_i(MEM_Rd), .mem_data_i(MEM_Result),
    .wb_we_i(WB_RegWrite), .wb_rd_i(WB_Rd), .wb_data_i(WB_Data),
    .data_o(fwd_rs)
  );

  operand_forward #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src_i(rt_q), .reg_data_i(rt_data_q),
    .mem_we_i(MEM_RegWrite), .mem_rd_i(MEM_Rd), .mem_data_i(MEM_Result),
    .wb_we_i(WB_RegWrite), .wb_rd_i(WB_Rd), .wb_data_i(WB_Data),
    .data_o(fwd_rt)
  );
`else
  logic raw_ex, raw_mem, raw_wb;
  logic unused_nofwd;

  // Without a bypass, any in-flight writer of a used source must drain first.
  assign raw_ex  = valid_q && regwrite_q &&
                   (src_hit(ID_UsesRs, ID_Rs, rd_q) || src_hit(ID_UsesRt, ID_Rt, rd_q));
  assign raw_mem = MEM_RegWrite &&
                   (src_hit(ID_UsesRs, ID_Rs, MEM_Rd) || src_hit(ID_UsesRt, ID_Rt, MEM_Rd));
  assign raw_wb  = WB_RegWrite &&
                   (src_hit(ID_UsesRs, ID_Rs, WB_Rd) || src_hit(ID_UsesRt, ID_Rt, WB_Rd));
  assign StallIF_ID = load_use || raw_ex || raw_mem || raw_wb;

  assign fwd_rs = rs_data_q;
  assign fwd_rt = rt_data_q;
  assign unused_nofwd = ^{MEM_Result, WB_Data, rs_q, rt_q};
`endif

  always_comb begin
    valid_d    = valid_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    aluop_d    = aluop_q;
    shamt_d    = shamt_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    if (!Hold) begin
      if (Flush || StallIF_ID) begin
        valid_d    = 1'b0;
        rs_d       = '0;
        rt_d       = '0;
        rd_d       = '0;
        rs_data_d  = '0;
        rt_data_d  = '0;
        imm_d      = '0;
        alusrc_d   = 1'b0;
        aluop_d    = OP_W'(ALU_NOP);
        shamt_d    = '0;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
      end else begin
        valid_d    = ID_Valid;
        rs_d       = ID_Rs;
        rt_d       = ID_Rt;
        rd_d       = ID_Rd;
        rs_data_d  = ID_RsData;
        rt_data_d  = ID_RtData;
        imm_d      = ID_Imm;
        alusrc_d   = ID_ALUSrc;
        aluop_d    = ID_ALUOperation;
        shamt_d    = ID_Shamt;
        regwrite_d = ID_RegWrite && ID_Valid;
        memread_d  = ID_MemRead  && ID_Valid;
        memwrite_d = ID_MemWrite && ID_Valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluop_q    <= OP_W'(ALU_NOP);
      shamt_q    <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
      shamt_q    <= shamt_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
    end
  end

  assign Operand1     = fwd_rs;
  assign Operand2     = alusrc_q ? imm_q : fwd_rt;
  assign EX_StoreData = fwd_rt;
  assign ALUOperation = aluop_q;
  assign Shamt        = shamt_q;
  assign EX_Rd        = rd_q;
  assign EX_Valid     = valid_q;
  assign EX_RegWrite  = regwrite_q;
  assign EX_MemRead   = memread_q;
  assign EX_MemWrite  = memwrite_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed stimulus pushes expectations, a negedge monitor checks them.
`default_nettype none

module tb_id_ex_stage;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, Hold, Flush;
  logic        ID_Valid, ID_UsesRs, ID_UsesRt, ID_ALUSrc;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd, ID_Shamt, ID_ALUOperation;
  logic [31:0] ID_RsData, ID_RtData, ID_Imm;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite;
  logic        MEM_RegWrite, WB_RegWrite;
  logic [4:0]  MEM_Rd, WB_Rd;
  logic [31:0] MEM_Result, WB_Data;
  logic [31:0] Operand1, Operand2, EX_StoreData;
  logic [4:0]  ALUOperation, Shamt, EX_Rd;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Valid, StallIF_ID;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] op1, op2, store;
    logic [18:0] ctl;
    logic        stall;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .Hold(Hold), .Flush(Flush),
    .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_Imm(ID_Imm),
    .ID_ALUSrc(ID_ALUSrc), .ID_ALUOperation(ID_ALUOperation), .ID_Shamt(ID_Shamt),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .MEM_RegWrite(MEM_RegWrite), .MEM_Rd(MEM_Rd), .MEM_Result(MEM_Result),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
    .Operand1(Operand1), .Operand2(Operand2), .ALUOperation(ALUOperation), .Shamt(Shamt),
    .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite), .EX_Valid(EX_Valid), .EX_StoreData(EX_StoreData),
    .StallIF_ID(StallIF_ID)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "stall", {31'd0, StallIF_ID}, {31'd0, e.stall});
        chk(e.name, "ctl", {13'd0, EX_Valid, ALUOperation, EX_Rd, Shamt,
                            EX_RegWrite, EX_MemRead, EX_MemWrite}, {13'd0, e.ctl});
        chk(e.name, "op1", Operand1, e.op1);
        chk(e.name, "op2", Operand2, e.op2);
        chk(e.name, "store", EX_StoreData, e.store);
      end
    end
  end

  task automatic expect_ex(input string nm, input logic [31:0] o1, input logic [31:0] o2,
                           input logic [31:0] st, input logic v, input logic [4:0] op,
                           input logic [4:0] rd, input logic [4:0] sh, input logic rw,
                           input logic mr, input logic mw, input logic stall);
    exp_t e;
    e.name = nm; e.op1 = o1; e.op2 = o2; e.store = st;
    e.ctl = {v, op, rd, sh, rw, mr, mw};
    e.stall = stall;
    sb.push_back(e);
  endtask

  task automatic expect_bubble(input string nm, input logic stall);
    expect_ex(nm, 32'h0, 32'h0, 32'h0, 1'b0, 5'b00001, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, stall);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic src, input logic [4:0] op, input logic [4:0] sh,
                        input logic rw, input logic mr, input logic mw);
    ID_Valid = v; ID_Rs = rs; ID_UsesRs = urs; ID_Rt = rt; ID_UsesRt = urt; ID_Rd = rd;
    ID_RsData = rsd; ID_RtData = rtd; ID_Imm = imm; ID_ALUSrc = src;
    ID_ALUOperation = op; ID_Shamt = sh;
    ID_RegWrite = rw; ID_MemRead = mr; ID_MemWrite = mw;
  endtask

  task automatic idle_id();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 0);
  endtask

  task automatic set_lw();
    set_id(1, 1, 1, 6, 0, 4, 32'h100, 32'h55, 32'h8, 1, 5'b00001, 0, 1, 1, 0);
  endtask

  task automatic set_x();
    set_id(1, 0, 0, 0, 0, 11, 32'h5A, 32'h6B, 0, 0, 5'b00100, 7, 1, 0, 1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; Hold = 1'b0; Flush = 1'b0;
    MEM_RegWrite = 1'b0; MEM_Rd = '0; MEM_Result = '0;
    WB_RegWrite = 1'b0; WB_Rd = '0; WB_Data = '0;
    idle_id();

    cyc();
    expect_bubble("rst_low", 1'b0);
    cyc();
    rst_n = 1'b1;
    expect_bubble("rst_release", 1'b0);

    set_id(1, 1, 1, 2, 1, 3, 32'd5, 32'd7, 0, 0, 5'b00001, 0, 1, 0, 0);
    cyc();
    set_id(1, 1, 1, 2, 1, 5, 32'd5, 32'd7, 32'h10, 1, 5'b01000, 3, 1, 0, 0);
    expect_ex("addu", 32'd5, 32'd7, 32'd7, 1, 5'b00001, 3, 0, 1, 0, 0, 0);
    cyc();
    set_lw();
    expect_ex("alusrc", 32'd5, 32'h10, 32'd7, 1, 5'b01000, 5, 3, 1, 0, 0, 0);
    cyc();
    set_id(1, 4, 1, 0, 0, 7, 32'h44, 0, 0, 0, 5'b00001, 0, 1, 0, 0);
    expect_ex("lw", 32'h100, 32'h8, 32'h55, 1, 5'b00001, 4, 0, 1, 1, 0, 1);
    cyc();
    set_lw();
    expect_bubble("loaduse_bubble", 1'b0);
    cyc();
    set_id(1, 0, 1, 0, 1, 7, 32'd9, 0, 0, 0, 5'b00001, 0, 1, 0, 0);
    expect_ex("loaduse_r0", 32'h100, 32'h8, 32'h55, 1, 5'b00001, 4, 0, 1, 1, 0, 0);
    cyc();
    MEM_RegWrite = 1; MEM_Rd = 0; MEM_Result = 32'hDEAD;
    WB_RegWrite = 1; WB_Rd = 0; WB_Data = 32'hBEEF;
    expect_ex("r0_guard", 32'd9, 32'd0, 32'd0, 1, 5'b00001, 7, 0, 1, 0, 0, 0);

    cyc();
    MEM_RegWrite = 0; WB_RegWrite = 0;
    Hold = 1; Flush = 1;
    set_id(1, 7, 1, 0, 0, 8, 32'h11, 0, 0, 0, 5'b00011, 0, 1, 0, 0);
    expect_ex("hold_pre", 32'd9, 32'd0, 32'd0, 1, 5'b00001, 7, 0, 1, 0, 0, !FWD);
    cyc();
    expect_ex("hold_flush", 32'd9, 32'd0, 32'd0, 1, 5'b00001, 7, 0, 1, 0, 0, !FWD);
    Hold = 0;
    cyc();
    Flush = 0;
    set_id(1, 3, 1, 3, 1, 9, 32'h33, 32'h33, 0, 0, 5'b00001, 0, 1, 0, 0);
    expect_bubble("flush", 1'b0);

    cyc();
    Hold = 1;
    MEM_RegWrite = 1; MEM_Rd = 3; MEM_Result = 32'hAA;
    WB_RegWrite = 1; WB_Rd = 3; WB_Data = 32'hBB;
    idle_id();
    expect_ex("fwd_mem", FWD ? 32'hAA : 32'h33, FWD ? 32'hAA : 32'h33, FWD ? 32'hAA : 32'h33,
              1, 5'b00001, 9, 0, 1, 0, 0, 0);
    cyc();
    MEM_RegWrite = 0;
    expect_ex("fwd_wb", FWD ? 32'hBB : 32'h33, FWD ? 32'hBB : 32'h33, FWD ? 32'hBB : 32'h33,
              1, 5'b00001, 9, 0, 1, 0, 0, 0);
    cyc();
    MEM_RegWrite = 1; MEM_Rd = 0;
    expect_ex("fwd_mem_r0", FWD ? 32'hBB : 32'h33, FWD ? 32'hBB : 32'h33, FWD ? 32'hBB : 32'h33,
              1, 5'b00001, 9, 0, 1, 0, 0, 0);

    cyc();
    Hold = 0;
    MEM_RegWrite = 1; MEM_Rd = 2; MEM_Result = 32'hAA;
    WB_RegWrite = 0;
    set_id(1, 0, 0, 2, 1, 10, 0, 32'h22, 0, 0, 5'b00010, 0, 1, 0, 0);
    expect_ex("stall_mem", 32'h33, 32'h33, 32'h33, 1, 5'b00001, 9, 0, 1, 0, 0, !FWD);
    cyc();
    MEM_RegWrite = 0;
    WB_RegWrite = 1; WB_Rd = 2; WB_Data = 32'hBB;
    expect_ex("stall_wb", 32'h0, FWD ? 32'hBB : 32'h0, FWD ? 32'hBB : 32'h0,
              FWD, FWD ? 5'b00010 : 5'b00001, FWD ? 5'd10 : 5'd0, 0, FWD, 0, 0, !FWD);
    cyc();
    WB_RegWrite = 0;
    expect_ex("stall_clear", 32'h0, FWD ? 32'h22 : 32'h0, FWD ? 32'h22 : 32'h0,
              FWD, FWD ? 5'b00010 : 5'b00001, FWD ? 5'd10 : 5'd0, 0, FWD, 0, 0, 0);
    cyc();
    set_x();
    expect_ex("resume", 32'h0, 32'h22, 32'h22, 1, 5'b00010, 10, 0, 1, 0, 0, 0);
    cyc();
    expect_ex("capture_x", 32'h5A, 32'h6B, 32'h6B, 1, 5'b00100, 11, 7, 1, 0, 1, 0);

    cyc();
    rst_n = 1'b0;
    expect_bubble("mid_reset", 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    expect_ex("post_reset", 32'h5A, 32'h6B, 32'h6B, 1, 5'b00100, 11, 7, 1, 0, 1, 0);
    set_id(0, 0, 0, 0, 0, 12, 32'h1, 32'h2, 0, 0, 5'b00101, 2, 1, 1, 1);
    cyc();
    idle_id();
    expect_ex("invalid_capture", 32'h1, 32'h2, 32'h2, 0, 5'b00101, 12, 2, 0, 0, 0, 0);

    repeat (3) cyc();
    chk("scoreboard", "pending", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
